set_cmd_sequencer: RTL and testbench

- Upstream command feeder for the circle-set candidate counter (SET).
- Buffers host queries (central, radius, mode, tag) in a small FIFO and issues them one at a time over SET's en/busy interface.
- Captures SET's one-cycle candidate/valid result into a tagged result slot with a valid/ready handshake.
- Watchdog flags a query whose result never arrives.

---
 rtl/set_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_set_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_cmd_sequencer.sv
// Command feeder for the circle-set candidate counter: queues host queries,
// issues them one at a time over SET's en/busy interface and returns tagged results.
module set_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [23:0]      cmd_central,
    input  logic [11:0]      cmd_radius,
    input  logic [1:0]       cmd_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             cmd_err,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
    output logic [2:0]       pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       state_reg;
    logic [WD_W-1:0]  wd_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             cmd_err_reg;
    logic [23:0]      set_central_reg;
    logic [11:0]      set_radius_reg;
    logic [1:0]       set_mode_reg;
    logic             res_valid_reg;
    logic [7:0]       res_candidate_reg;
    logic [TAG_W-1:0] res_tag_reg;
    logic             res_timeout_reg;

    logic full;
    logic accept;
    logic push;
    logic pop;

    assign full   = (count_reg == CNT_W'(DEPTH));
    assign accept = cmd_valid && !full;
    assign push   = accept && (cmd_mode != MODE_ILLEGAL);
    // Issue only when SET is listening and the result slot is free: one query in flight.
    assign pop    = (state_reg == ST_IDLE) && (count_reg != '0) && !set_busy && !res_valid_reg;
    assign head   = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= '{central: cmd_central, radius: cmd_radius,
                                      mode: cmd_mode, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            state_reg         <= ST_IDLE;
            wd_reg            <= '0;
            tag_reg           <= '0;
            cmd_err_reg       <= 1'b0;
            set_central_reg   <= '0;
            set_radius_reg    <= '0;
            set_mode_reg      <= '0;
            res_valid_reg     <= 1'b0;
            res_candidate_reg <= '0;
            res_tag_reg       <= '0;
            res_timeout_reg   <= 1'b0;
        end else begin
            cmd_err_reg <= accept && (cmd_mode == MODE_ILLEGAL);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        set_central_reg <= head.central;
                        set_radius_reg  <= head.radius;
                        set_mode_reg    <= head.mode;
                        tag_reg         <= head.tag;
                        state_reg       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the expiry cycle still counts as a real answer.
                    if (set_valid) begin
                        res_candidate_reg <= set_candidate;
                        res_tag_reg       <= tag_reg;
                        res_timeout_reg   <= 1'b0;
                        res_valid_reg     <= 1'b1;
                        state_reg         <= ST_IDLE;
                    end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                        // Aborts carry the abandoned query's tag so the host knows which one died.
                        res_candidate_reg <= '0;
                        res_tag_reg       <= tag_reg;
                        res_timeout_reg   <= 1'b1;
                        res_valid_reg     <= 1'b1;
                        state_reg         <= ST_IDLE;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready     = !full;
    assign cmd_err       = cmd_err_reg;
    assign set_en        = (state_reg == ST_ISSUE);
    assign set_central   = set_central_reg;
    assign set_radius    = set_radius_reg;
    assign set_mode      = set_mode_reg;
    assign res_valid     = res_valid_reg;
    assign res_candidate = res_candidate_reg;
    assign res_tag       = res_tag_reg;
    assign res_timeout   = res_timeout_reg;
    assign pending       = (32'(count_reg) > 7) ? 3'd7 : 3'(count_reg);

endmodule

// File: tb/tb_set_cmd_sequencer.sv
// Bench for set_cmd_sequencer: directed scenarios plus random traffic against a
// time-window reference model and a behavioural SET responder.
module tb_set_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_central;
    logic [11:0]      cmd_radius;
    logic [1:0]       cmd_mode;
    logic [TAG_W-1:0] cmd_tag;
    logic             cmd_err;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_timeout;
    logic [2:0]       pending;

    logic busy_int;
    logic busy_force;
    assign set_busy = busy_int | busy_force;

    always #5 clk = ~clk;

    set_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_central(cmd_central),
        .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag), .cmd_err(cmd_err),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_tag(res_tag), .res_timeout(res_timeout), .pending(pending)
    );

    int checks = 0;
    int failures = 0;

    // SET responder: samples a query on the edge after set_en, answers set_lat cycles later.
    int         set_lat = 10;
    bit         set_rand = 1'b1;
    logic [7:0] set_ans = 8'd0;

    initial begin
        int lat_now;
        busy_int = 1'b0; set_valid = 1'b0; set_candidate = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (set_en === 1'b1) begin
                lat_now = set_lat;
                @(posedge clk); #1;
                busy_int = 1'b1;
                repeat (lat_now - 1) @(posedge clk);
                #1;
                set_valid = 1'b1;
                set_candidate = set_rand ? 8'($urandom) : set_ans;
                @(posedge clk); #1;
                set_valid = 1'b0;
                busy_int = 1'b0;
            end
        end
    end

    // Reference model: FIFO as a queue, outstanding query tracked by its issue edge number.
    typedef struct packed {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mq[$];
    logic [TAG_W-1:0] got_tags[$];
    longint           edge_n = 0;
    longint           issue_edge = -10;
    bit               outstanding = 1'b0;
    logic [TAG_W-1:0] out_tag = '0;
    bit               m_rv = 1'b0, m_rto = 1'b0, m_err = 1'b0, last_push_ok = 1'b0;
    logic [7:0]       m_rc = '0;
    logic [TAG_W-1:0] m_rt = '0;
    logic [23:0]      m_sc = '0;
    logic [11:0]      m_sr = '0;
    logic [1:0]       m_sm = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $error("FAIL %s observed=no_event expected=event_within_bound", name);
    endtask

    task automatic cycle();
        logic             s_rst, s_cv, s_bsy, s_sv, s_rr, s_rv;
        logic [23:0]      s_cc;
        logic [11:0]      s_cr;
        logic [1:0]       s_cm;
        logic [TAG_W-1:0] s_ct, s_rtag;
        logic [7:0]       s_cand;
        bit               pre_out, pre_rv, push_ok, done, pop;
        entry_t           e;
        @(negedge clk);
        s_rst = rst; s_cv = cmd_valid; s_cc = cmd_central; s_cr = cmd_radius; s_cm = cmd_mode;
        s_ct = cmd_tag; s_bsy = set_busy; s_sv = set_valid; s_cand = set_candidate;
        s_rr = res_ready; s_rv = res_valid; s_rtag = res_tag;
        @(posedge clk);
        edge_n++;
        #2;
        if (s_rst) begin
            mq.delete();
            outstanding = 1'b0; m_rv = 1'b0; m_rc = '0; m_rt = '0; m_rto = 1'b0; m_err = 1'b0;
            m_sc = '0; m_sr = '0; m_sm = '0; last_push_ok = 1'b0;
        end else begin
            if (s_rv === 1'b1 && s_rr) got_tags.push_back(s_rtag);
            pre_out = outstanding;
            pre_rv  = m_rv;
            push_ok = s_cv && (mq.size() < DEPTH) && (s_cm != 2'd3);
            m_err   = s_cv && (mq.size() < DEPTH) && (s_cm == 2'd3);
            done = 1'b0;
            if (outstanding) begin
                if (edge_n >= issue_edge + 2 && s_sv) begin
                    m_rc = s_cand; m_rto = 1'b0; done = 1'b1;
                end else if (edge_n == issue_edge + 1 + TIMEOUT) begin
                    m_rc = '0; m_rto = 1'b1; done = 1'b1;
                end
                if (done) begin
                    m_rt = out_tag; outstanding = 1'b0;
                end
            end
            if (pre_rv && s_rr) m_rv = 1'b0;
            if (done) m_rv = 1'b1;
            pop = !pre_out && (mq.size() > 0) && !s_bsy && !pre_rv;
            if (pop) begin
                e = mq.pop_front();
                m_sc = e.central; m_sr = e.radius; m_sm = e.mode; out_tag = e.tag;
                outstanding = 1'b1; issue_edge = edge_n;
            end
            if (push_ok) mq.push_back('{central: s_cc, radius: s_cr, mode: s_cm, tag: s_ct});
            last_push_ok = push_ok;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
        chk("pending", 32'(pending), (mq.size() > 7) ? 32'd7 : 32'(mq.size()));
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
        chk("set_en", 32'(set_en), 32'(outstanding && issue_edge == edge_n));
        chk("set_central", 32'(set_central), 32'(m_sc));
        chk("set_radius", 32'(set_radius), 32'(m_sr));
        chk("set_mode", 32'(set_mode), 32'(m_sm));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_candidate", 32'(res_candidate), 32'(m_rc));
        chk("res_tag", 32'(res_tag), 32'(m_rt));
        chk("res_timeout", 32'(res_timeout), 32'(m_rto));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_hold(input logic [23:0] c, input logic [11:0] r,
                             input logic [1:0] m, input logic [TAG_W-1:0] t);
        int n = 0;
        cmd_valid = 1'b1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t;
        do begin
            cycle();
            n++;
        end while (!last_push_ok && n < 600);
        if (!last_push_ok) bound_fail("push_accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cycles);
        int n = 0;
        while ((outstanding || mq.size() != 0 || m_rv || set_busy !== 1'b0) && n < max_cycles) begin
            cycle();
            n++;
        end
        if (n >= max_cycles) bound_fail("wait_quiet");
    endtask

    task automatic wait_res(input string name, input int max_cycles);
        int n = 0;
        while (res_valid !== 1'b1 && n < max_cycles) begin
            cycle();
            n++;
        end
        chk(name, 32'(res_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
        cmd_tag = '0; res_ready = 1'b1; busy_force = 1'b0;
        run(2);
        rst = 1'b0;
        cycle();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Single query with nominal SET latency
        set_rand = 1'b0; set_ans = 8'd29; set_lat = 195; res_ready = 1'b0;
        push_hold(24'h446600, 12'h330, 2'd0, 4'd5);
        chk("t1_en_early", 32'(set_en), 32'd0);
        cycle();
        chk("t1_en", 32'(set_en), 32'd1);
        wait_res("t1_res_valid", 300);
        chk("t1_cand", 32'(res_candidate), 32'd29);
        chk("t1_tag", 32'(res_tag), 32'd5);
        chk("t1_timeout", 32'(res_timeout), 32'd0);
        res_ready = 1'b1;
        wait_quiet(50);

        // Five back-to-back pushes with SET held busy so the FIFO fills
        set_rand = 1'b1; set_lat = 3; busy_force = 1'b1; got_tags.delete();
        for (int i = 0; i < 4; i++) push_hold(24'($urandom), 12'($urandom), 2'(i % 3), 4'(i));
        chk("t2_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_tag = 4'd4; cmd_mode = 2'd1;
        run(3);
        chk("t2_held_pending", 32'(pending), 32'd4);
        busy_force = 1'b0;
        push_hold(24'h123450, 12'h560, 2'd1, 4'd4);
        wait_quiet(400);
        chk("t2_count", 32'(got_tags.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_tags.size(); i++) chk("t2_order", 32'(got_tags[i]), 32'(i));

        // Illegal mode
        cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_tag = 4'd7;
        cycle();
        cmd_valid = 1'b0;
        chk("t3_err", 32'(cmd_err), 32'd1);
        chk("t3_pending", 32'(pending), 32'd0);
        cycle();
        chk("t3_err_drop", 32'(cmd_err), 32'd0);
        run(4);
        chk("t3_no_en", 32'(set_en), 32'd0);

        // Watchdog expiry, then a late answer that must be ignored
        set_lat = 300; res_ready = 1'b0;
        push_hold(24'h112200, 12'h220, 2'd1, 4'd9);
        wait_res("t4_res_valid", 400);
        chk("t4_timeout", 32'(res_timeout), 32'd1);
        chk("t4_cand", 32'(res_candidate), 32'd0);
        chk("t4_tag", 32'(res_tag), 32'd9);
        run(60);
        chk("t4_late_cand", 32'(res_candidate), 32'd0);
        chk("t4_late_timeout", 32'(res_timeout), 32'd1);
        res_ready = 1'b1;
        wait_quiet(200);

        // Full result slot blocks the next issue
        set_lat = 5; res_ready = 1'b0;
        push_hold(24'h334400, 12'h120, 2'd2, 4'd1);
        push_hold(24'h556600, 12'h450, 2'd0, 4'd2);
        run(40);
        chk("t5_pending", 32'(pending), 32'd1);
        chk("t5_slot", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        cycle();
        chk("t5_no_en_on_consume", 32'(set_en), 32'd0);
        cycle();
        chk("t5_issue", 32'(set_en), 32'd1);
        wait_quiet(100);

        // Reset while waiting for SET
        set_lat = 195;
        push_hold(24'h778800, 12'h660, 2'd1, 4'd3);
        run(60);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_en", 32'(set_en), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
        chk("t6_central", 32'(set_central), 32'd0);
        wait_quiet(300);
        set_lat = 10; set_rand = 1'b0; set_ans = 8'hA5;
        push_hold(24'h990000, 12'h770, 2'd2, 4'd6);
        wait_res("t6_after_res", 100);
        chk("t6_after_cand", 32'(res_candidate), 32'hA5);
        chk("t6_after_tag", 32'(res_tag), 32'd6);
        wait_quiet(50);

        // Random traffic
        set_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            cmd_valid   = ($urandom % 3) == 0;
            cmd_central = 24'($urandom);
            cmd_radius  = 12'($urandom);
            cmd_mode    = 2'($urandom % 4);
            cmd_tag     = 4'($urandom);
            res_ready   = ($urandom % 4) != 0;
            set_lat     = $urandom_range(1, 15);
            busy_force  = ($urandom % 16) == 0;
            cycle();
        end
        cmd_valid = 1'b0; busy_force = 1'b0; res_ready = 1'b1;
        wait_quiet(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
